// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared state encodings, halt causes and defaults for the run-control sequencer
package cpu_run_ctrl_pkg;
    localparam int CNT_W_DEF = 16;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_HALT  = 3'd4
    } state_t;
    localparam logic [2:0] HC_NONE = 3'd0;
    localparam logic [2:0] HC_STOP = 3'd1;
    localparam logic [2:0] HC_STEP = 3'd2;
    localparam logic [2:0] HC_BP   = 3'd3;
    localparam logic [2:0] HC_ERR  = 3'd4;
    localparam logic [2:0] HC_WDOG = 3'd5;
endpackage

// File: rtl/cpu_bp_unit.sv
// cpu_bp_unit: PC breakpoint compare with a skip flag so a resume at the breakpoint advances past it
module cpu_bp_unit
    import cpu_run_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       bp_en,
    input  logic [7:0] bp_addr,
    input  logic [7:0] pc,
    input  logic       set_skip,
    input  logic       clr_skip,
    input  logic       cpu_en,
    output logic       bp_hit
);
    logic skip_bp;

    assign bp_hit = bp_en && (pc == bp_addr) && !skip_bp;

    // skip is armed on resume and dropped once an instruction actually retires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) skip_bp <= 1'b0;
        else if (set_skip) skip_bp <= 1'b1;
        else if (clr_skip || cpu_en) skip_bp <= 1'b0;
    end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: start/stop/step run-control for the stack CPU; optional instruction watchdog via WATCHDOG_EN
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MAX_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clear,
    input  logic             bp_en,
    input  logic [7:0]       bp_addr,
    input  logic [7:0]       pc,
    input  logic             cpu_error,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic [2:0]       state,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] instr_count
);
    state_t st;
    logic bp_hit, wdog, resume_ok, set_skip;

    assign state     = st;
    assign resume_ok = (st == S_HALT) && (halt_cause != HC_ERR) && !clear;
    assign set_skip  = resume_ok && (start || step);
    assign cpu_en    = !clear && ((st == S_RUN) ? !(cpu_error || bp_hit || stop || wdog)
                                                : ((st == S_STEP) && !cpu_error));

    cpu_bp_unit u_bp (
        .clk      (clk),
        .reset    (reset),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (pc),
        .set_skip (set_skip),
        .clr_skip (st == S_CLEAR),
        .cpu_en   (cpu_en),
        .bp_hit   (bp_hit)
    );

`ifdef WATCHDOG_EN
    localparam int SEG_W = $clog2(MAX_CYCLES + 1);
    logic [SEG_W-1:0] seg_count;

    assign wdog = (seg_count == SEG_W'(MAX_CYCLES));

    // instructions retired in RUN since the segment began
    always_ff @(posedge clk or posedge reset) begin
        if (reset) seg_count <= '0;
        else if (st == S_CLEAR || (resume_ok && start)) seg_count <= '0;
        else if (st == S_RUN && cpu_en) seg_count <= seg_count + 1'b1;
    end
`else
    assign wdog = 1'b0;
`endif

    // saturating count of retired instructions since the last fresh start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) instr_count <= '0;
        else if (st == S_CLEAR) instr_count <= '0;
        else if (cpu_en && !(&instr_count)) instr_count <= instr_count + 1'b1;
    end

    // run-control FSM; cpu_rst is raised only for the single CLEAR cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= S_IDLE;
            cpu_rst    <= 1'b0;
            halt_cause <= HC_NONE;
        end else begin
            cpu_rst <= 1'b0;
            if (clear) begin
                st         <= S_IDLE;
                halt_cause <= HC_NONE;
            end else begin
                case (st)
                    S_IDLE: if (start) begin
                        st      <= S_CLEAR;
                        cpu_rst <= 1'b1;
                    end
                    S_CLEAR: begin
                        st         <= S_RUN;
                        halt_cause <= HC_NONE;
                    end
                    S_RUN: if (!cpu_en) begin
                        st         <= S_HALT;
                        halt_cause <= cpu_error ? HC_ERR : bp_hit ? HC_BP : stop ? HC_STOP : HC_WDOG;
                    end
                    S_STEP: begin
                        st         <= S_HALT;
                        halt_cause <= cpu_error ? HC_ERR : HC_STEP;
                    end
                    S_HALT: if (resume_ok && (start || step)) begin
                        st         <= start ? S_RUN : S_STEP;
                        halt_cause <= HC_NONE;
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run-control sequencer for the 8-bit stack CPU: owns the CPU's clock-enable and synchronous clear, and implements start/stop/single-step.
- Halts on PC breakpoint or on the CPU error flag.
- Counts executed instructions.
- Sits between the board/testbench controls and the CPU core; the CPU advances only on cycles where cpu_en=1.

Parameters:
CNT_W, 16, width of executed-instruction counter (saturating)
MAX_CYCLES, 255, watchdog limit on instructions per run segment (used only with WATCHDOG_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  level-sampled pulse: IDLE→fresh run, HALT→resume
stop  in  1  pulse: request halt while running
step  in  1  pulse: execute exactly one instruction from HALT
clear  in  1  pulse: abort to IDLE from any state
bp_en  in  1  breakpoint enable
bp_addr  in  8  breakpoint PC value
pc  in  8  current CPU PC
cpu_error  in  1  CPU sticky error flag
cpu_en  out  1  CPU clock-enable, combinational from state and inputs
cpu_rst  out  1  CPU clear, registered, one-cycle pulse
state  out  3  FSM state encoding
halt_cause  out  3  0 none, 1 stop, 2 step done, 3 breakpoint, 4 error, 5 watchdog
instr_count  out  CNT_W  instructions executed since last fresh start

Behaviour:
- Reset (async): state=IDLE, cpu_en=0, cpu_rst=0, halt_cause=0, instr_count=0, skip_bp=0, seg_count=0.
- States: IDLE=0, CLEAR=1, RUN=2, STEP=3, HALT=4.
- clear has highest priority in every state: next=IDLE, halt_cause=0, cpu_en=0 that cycle.
- IDLE: start → CLEAR. step and stop are ignored.
- CLEAR: lasts one cycle.
  - cpu_rst=1, instr_count←0, seg_count←0, skip_bp←0.
  - Next state is RUN.
- RUN: per cycle, evaluate in priority order:
  1. cpu_error → HALT, cause 4.
  2. bp_hit → HALT, cause 3.
  3. stop → HALT, cause 1.
  4. watchdog → HALT, cause 5.
  5. Otherwise cpu_en=1 and the instruction retires.
  - Halting cycles have cpu_en=0, so the instruction at bp_addr is NOT executed.
- bp_hit = bp_en & (pc==bp_addr) & ~skip_bp.
  - skip_bp is set on resume from HALT (start or step).
  - skip_bp clears after the first cpu_en=1 cycle, so resuming at a breakpoint advances past it.
- STEP: entered from HALT on step.
  - One cycle; cpu_en=1 unless cpu_error (then cause 4, no execute).
  - Next state is HALT, cause 2.
- HALT: cpu_en=0.
  - start → RUN, skip_bp=1, seg_count←0.
  - step → STEP, skip_bp=1.
  - If cause==4, start and step are ignored; only clear exits.
  - start and step in the same cycle: start wins.
- RUN with start and stop in the same cycle: stop wins (start is meaningless in RUN).
- instr_count: +1 on every cpu_en=1 cycle; saturates at all-ones, no wrap.
- cpu_rst is never asserted outside CLEAR.
- reset mid-RUN forces IDLE immediately; the CPU itself is reset by its own reset input.
- cpu_error rising in the same cycle as bp_hit reports cause 4.

Optional Feature:
WATCHDOG_EN
- Defined: seg_count counts cpu_en cycles in RUN since entry.
  - When seg_count==MAX_CYCLES at RUN evaluation → HALT, cause 5, no execute.
  - Resume resets seg_count.
- Undefined: no seg_count register, cause 5 is never produced, and MAX_CYCLES is unused.

Decomposition:
- Shared package: state encodings (S_IDLE..S_HALT), halt-cause constants (HC_NONE..HC_WDOG), CNT_W default.
- One natural sub-module: cpu_bp_unit (bp_en/bp_addr/pc compare plus skip_bp register) producing bp_hit.
- FSM and counters stay in the top.

Test Plan:
1. Reset then start → cpu_rst high exactly 1 cycle (state=1), then state=2, cpu_en=1; after 10 cycles instr_count=10.
2. bp_en=1, bp_addr=8'h05, pc increments 0..5 → HALT at pc=5, halt_cause=3, instr_count=5; start → executes pc 5 (no re-halt), continues to RUN.
3. In HALT, step ×3 → three single cpu_en pulses, each followed by state=4, cause=2, instr_count+3.
4. RUN, cpu_error=1 → same-cycle cpu_en=0, HALT cause=4; start/step ignored; clear → IDLE, cause=0.
5. RUN, start and stop asserted together → HALT cause=1; clear and start together in HALT → IDLE.
6. WATCHDOG_EN, MAX_CYCLES=4 → after 4 executed instructions HALT cause=5; start → 4 more, instr_count=8; without the macro, no halt after 300 cycles.
